// File: rtl/alarm_ring_scheduler_pkg.sv
// +------------------------------------------------------------------------+
// | Module : alarm_ring_scheduler_pkg                                      |
// | Brief  : Shared types and constants for the buzzer ring scheduler.     |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package alarm_ring_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } ring_state_e;

    localparam int SRC_TIMER       = 0;
    localparam int SRC_CLOCK_ALARM = 1;
    localparam int SRC_STOPWATCH   = 2;
    localparam int SRC_SPARE       = 3;

    // Defaults assume a 100 Hz tick.
    localparam int DEF_ON_TICKS     = 50;
    localparam int DEF_OFF_TICKS    = 50;
    localparam int DEF_RING_TIMEOUT = 6000;
    localparam int DEF_SNOOZE_TICKS = 30000;

    // Bits needed to hold values 0..terminal (never less than one).
    function automatic int cnt_width(input int terminal);
        return (terminal > 0) ? $clog2(terminal + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_ring_scheduler_if.sv
// +------------------------------------------------------------------------+
// | Module : alarm_ring_scheduler_if                                       |
// | Brief  : Request/control/status bundle between datapath and scheduler. |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
`default_nettype none

interface alarm_ring_scheduler_if
    import alarm_ring_scheduler_pkg::*;
#(
    parameter int NUM_SRC = 4
);
    localparam int SRC_W = cnt_width(NUM_SRC - 1);

    logic [NUM_SRC-1:0] ringRequest;
    logic [NUM_SRC-1:0] enableMask;
    logic               dismiss;
    logic               snooze;
    logic               clearMissed;
    logic               ringSound;
    logic               activeValid;
    logic [SRC_W-1:0]   activeSource;
    logic [NUM_SRC-1:0] pendingMask;
    logic [NUM_SRC-1:0] missedMask;

    modport master (
        output ringRequest, enableMask, dismiss, snooze, clearMissed,
        input  ringSound, activeValid, activeSource, pendingMask, missedMask
    );

    modport slave (
        input  ringRequest, enableMask, dismiss, snooze, clearMissed,
        output ringSound, activeValid, activeSource, pendingMask, missedMask
    );

endinterface

`default_nettype wire

// File: rtl/alarm_ring_scheduler_cadence.sv
// +------------------------------------------------------------------------+
// | Module : ring_cadence_gen                                              |
// | Brief  : On/off buzzer cadence counter with synchronous restart.       |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module ring_cadence_gen
    import alarm_ring_scheduler_pkg::*;
#(
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS
) (
    input  wire logic clockSignal,
    input  wire logic resetN,
    input  wire logic restart_i,
    input  wire logic advance_i,
    output logic      on_o
);
    localparam int PERIOD = ON_TICKS + OFF_TICKS;
    localparam int CW     = cnt_width(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (advance_i) begin
            cnt_d = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clockSignal) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign on_o = (int'(cnt_q) < ON_TICKS);

endmodule

`default_nettype wire

// File: rtl/alarm_ring_scheduler.sv
// +------------------------------------------------------------------------+
// | Module : alarm_ring_scheduler                                          |
// | Brief  : Fixed-priority, non-preemptive buzzer sharing with timeout.   |
// |          ALARM_SNOOZE_EN builds the optional SNOOZE state.             |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module alarm_ring_scheduler
    import alarm_ring_scheduler_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int ON_TICKS     = DEF_ON_TICKS,
    parameter int OFF_TICKS    = DEF_OFF_TICKS,
    parameter int RING_TIMEOUT = DEF_RING_TIMEOUT,
    parameter int SNOOZE_TICKS = DEF_SNOOZE_TICKS
) (
    input  wire logic             clockSignal,
    input  wire logic             resetN,
    alarm_ring_scheduler_if.slave bus
);
    localparam int SRC_W = cnt_width(NUM_SRC - 1);
    localparam int TW    = cnt_width(RING_TIMEOUT - 1);

    ring_state_e        state_q, state_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [TW-1:0]      tout_q, tout_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] missed_q, missed_d;
    logic [NUM_SRC-1:0] clr_pend, set_missed;
    logic [SRC_W-1:0]   grant_idx;
    logic               cad_restart, cad_on;

`ifdef ALARM_SNOOZE_EN
    localparam int SW = cnt_width(SNOOZE_TICKS - 1);
    logic [SW-1:0] snz_q, snz_d;
`else
    logic unused_snooze;
    assign unused_snooze = bus.snooze | (SNOOZE_TICKS == 0);
`endif

    // Lowest set index wins; scan downwards so it overwrites last.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_q[i]) grant_idx = SRC_W'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        tout_d      = tout_q;
        clr_pend    = '0;
        set_missed  = '0;
        cad_restart = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snz_d       = snz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|pend_q) begin
                    state_d     = ST_RING;
                    src_d       = grant_idx;
                    tout_d      = '0;
                    cad_restart = 1'b1;
                end
            end
            ST_RING: begin
                tout_d = tout_q + TW'(1);
                if (!bus.enableMask[src_q]) begin
                    state_d = ST_IDLE;
                    tout_d  = '0;
                end else if (bus.dismiss) begin
                    clr_pend[src_q] = 1'b1;
                    state_d         = ST_IDLE;
                    tout_d          = '0;
                end else if (tout_q == TW'(RING_TIMEOUT - 1)) begin
                    set_missed[src_q] = 1'b1;
                    clr_pend[src_q]   = 1'b1;
                    state_d           = ST_IDLE;
                    tout_d            = '0;
`ifdef ALARM_SNOOZE_EN
                end else if (bus.snooze) begin
                    state_d = ST_SNOOZE;
                    snz_d   = '0;
`endif
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                snz_d = snz_q + SW'(1);
                if (!bus.enableMask[src_q]) begin
                    state_d = ST_IDLE;
                end else if (bus.dismiss) begin
                    clr_pend[src_q] = 1'b1;
                    state_d         = ST_IDLE;
                end else if (snz_q == SW'(SNOOZE_TICKS - 1)) begin
                    state_d     = ST_RING;
                    tout_d      = '0;
                    cad_restart = 1'b1;
                    snz_d       = '0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // A new request in the same cycle as a clear survives unless masked.
    assign pend_d   = ((pend_q & ~clr_pend) | bus.ringRequest) & bus.enableMask;
    assign missed_d = (bus.clearMissed ? '0 : missed_q) | set_missed;

    always_ff @(posedge clockSignal) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            tout_q   <= '0;
            pend_q   <= '0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            tout_q   <= tout_d;
            pend_q   <= pend_d;
            missed_q <= missed_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clockSignal) begin
        if (!resetN) begin
            snz_q <= '0;
        end else begin
            snz_q <= snz_d;
        end
    end
`endif

    ring_cadence_gen #(
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS)
    ) u_cadence (
        .clockSignal (clockSignal),
        .resetN      (resetN),
        .restart_i   (cad_restart),
        .advance_i   (state_q == ST_RING),
        .on_o        (cad_on)
    );

    assign bus.ringSound    = (state_q == ST_RING) && cad_on;
    assign bus.activeValid  = (state_q != ST_IDLE);
    assign bus.activeSource = src_q;
    assign bus.pendingMask  = pend_q;
    assign bus.missedMask   = missed_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_ring_scheduler.sv
// +------------------------------------------------------------------------+
// | Module : tb_alarm_ring_scheduler                                       |
// | Brief  : Directed vector bench for alarm_ring_scheduler.               |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_alarm_ring_scheduler;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alarm_ring_scheduler_if #(.NUM_SRC(4)) bus ();

    alarm_ring_scheduler #(
        .NUM_SRC      (4),
        .ON_TICKS     (2),
        .OFF_TICKS    (2),
        .RING_TIMEOUT (20),
        .SNOOZE_TICKS (10)
    ) dut (
        .clockSignal (clk),
        .resetN      (resetN),
        .bus         (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic       dis;
        logic       snd;
        logic       val;
        logic [1:0] src;
        logic [3:0] pend;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_all(input string nm, input logic snd, input logic val,
                           input logic [1:0] src, input logic [3:0] pend, input logic [3:0] miss);
        chk({nm, ".ringSound"},    32'(bus.ringSound),    32'(snd));
        chk({nm, ".activeValid"},  32'(bus.activeValid),  32'(val));
        chk({nm, ".activeSource"}, 32'(bus.activeSource), 32'(src));
        chk({nm, ".pendingMask"},  32'(bus.pendingMask),  32'(pend));
        chk({nm, ".missedMask"},   32'(bus.missedMask),   32'(miss));
    endtask

    function automatic vec_t mk(input logic [3:0] req, input logic dis, input logic snd,
                                input logic val, input logic [1:0] src, input logic [3:0] pend);
        vec_t v;
        v.req = req; v.dis = dis; v.snd = snd; v.val = val; v.src = src; v.pend = pend;
        return v;
    endfunction

    initial begin
        // Single request, cadence 1,1,0,0, dismiss; then priority and non-preemption.
        vecs[0]  = mk(4'b0010, 0, 0, 0, 2'd0, 4'b0010);
        vecs[1]  = mk(4'b0000, 0, 1, 1, 2'd1, 4'b0010);
        vecs[2]  = mk(4'b0000, 0, 1, 1, 2'd1, 4'b0010);
        vecs[3]  = mk(4'b0000, 0, 0, 1, 2'd1, 4'b0010);
        vecs[4]  = mk(4'b0000, 0, 0, 1, 2'd1, 4'b0010);
        vecs[5]  = mk(4'b0000, 0, 1, 1, 2'd1, 4'b0010);
        vecs[6]  = mk(4'b0000, 1, 0, 0, 2'd1, 4'b0000);
        vecs[7]  = mk(4'b0000, 0, 0, 0, 2'd1, 4'b0000);
        vecs[8]  = mk(4'b0110, 0, 0, 0, 2'd1, 4'b0110);
        vecs[9]  = mk(4'b0000, 0, 1, 1, 2'd1, 4'b0110);
        vecs[10] = mk(4'b0000, 1, 0, 0, 2'd1, 4'b0100);
        vecs[11] = mk(4'b0000, 0, 1, 1, 2'd2, 4'b0100);
        vecs[12] = mk(4'b0001, 0, 1, 1, 2'd2, 4'b0101);
        vecs[13] = mk(4'b0000, 0, 0, 1, 2'd2, 4'b0101);
        vecs[14] = mk(4'b0000, 1, 0, 0, 2'd2, 4'b0001);
        vecs[15] = mk(4'b0000, 0, 1, 1, 2'd0, 4'b0001);

        bus.ringRequest = '0;
        bus.enableMask  = 4'b1111;
        bus.dismiss     = 1'b0;
        bus.snooze      = 1'b0;
        bus.clearMissed = 1'b0;

        step(); step();
        chk_all("reset", 0, 0, 2'd0, 4'b0000, 4'b0000);
        resetN = 1'b1;
        step();
        chk_all("post_reset_idle", 0, 0, 2'd0, 4'b0000, 4'b0000);

        for (int i = 0; i < 16; i++) begin
            bus.ringRequest = vecs[i].req;
            bus.dismiss     = vecs[i].dis;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].snd, vecs[i].val, vecs[i].src, vecs[i].pend, 4'b0000);
        end
        bus.ringRequest = '0;
        bus.dismiss     = 1'b0;

        // Source 0 ringing since vec15 (timeout count 0); let it time out, clear racing the set.
        for (int k = 1; k <= 19; k++) begin
            step();
            chk($sformatf("to_val%0d", k), 32'(bus.activeValid), 32'd1);
            chk($sformatf("to_snd%0d", k), 32'(bus.ringSound), 32'((k % 4) < 2));
        end
        bus.clearMissed = 1'b1;
        step();
        chk_all("timeout_exit", 0, 0, 2'd0, 4'b0000, 4'b0001);
        step();
        chk_all("clear_missed", 0, 0, 2'd0, 4'b0000, 4'b0000);
        bus.clearMissed = 1'b0;

        // Dismiss on the very cycle the timeout would fire.
        bus.ringRequest = 4'b0100;
        step();
        bus.ringRequest = '0;
        step();
        chk_all("to2_grant", 1, 1, 2'd2, 4'b0100, 4'b0000);
        for (int k = 1; k <= 19; k++) step();
        chk("to2_last_val", 32'(bus.activeValid), 32'd1);
        bus.dismiss = 1'b1;
        step();
        bus.dismiss = 1'b0;
        chk_all("dismiss_at_timeout", 0, 0, 2'd2, 4'b0000, 4'b0000);

        // Snooze at ring cycle 3 on source 3.
        bus.ringRequest = 4'b1000;
        step();
        bus.ringRequest = '0;
        step();
        chk_all("snz_grant", 1, 1, 2'd3, 4'b1000, 4'b0000);
        step(); step();
        chk("snz_cyc3_snd", 32'(bus.ringSound), 32'd0);
        bus.snooze = 1'b1;
        step();
        bus.snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        chk_all("snz_enter", 0, 1, 2'd3, 4'b1000, 4'b0000);
        for (int k = 1; k <= 9; k++) begin
            bus.snooze = (k == 4);
            step();
            chk($sformatf("snz_quiet%0d", k), {30'd0, bus.ringSound, bus.activeValid}, 32'b01);
        end
        bus.snooze = 1'b0;
        step();
        chk_all("snz_resume", 1, 1, 2'd3, 4'b1000, 4'b0000);
        for (int k = 1; k <= 19; k++) begin
            step();
            chk($sformatf("snz_to_snd%0d", k), 32'(bus.ringSound), 32'((k % 4) < 2));
        end
        chk("snz_to_val", 32'(bus.activeValid), 32'd1);
        step();
        chk_all("snz_timeout", 0, 0, 2'd3, 4'b0000, 4'b1000);
        bus.clearMissed = 1'b1;
        step();
        bus.clearMissed = 1'b0;
        chk("snz_clear", 32'(bus.missedMask), 32'd0);
`else
        // Ring cycle 4 onward continues the cadence untouched.
        for (int n = 4; n <= 13; n++) begin
            if (n > 4) begin
                bus.snooze = (n == 8);
                step();
            end
            chk($sformatf("nosnz_snd%0d", n), 32'(bus.ringSound), 32'(((n - 1) % 4) < 2));
            chk($sformatf("nosnz_val%0d", n), 32'(bus.activeValid), 32'd1);
        end
        bus.snooze  = 1'b0;
        bus.dismiss = 1'b1;
        step();
        bus.dismiss = 1'b0;
        chk_all("nosnz_dismiss", 0, 0, 2'd3, 4'b0000, 4'b0000);
`endif

        // Mask the active source.
        bus.ringRequest = 4'b0010;
        step();
        bus.ringRequest = '0;
        step();
        chk_all("mask_grant", 1, 1, 2'd1, 4'b0010, 4'b0000);
        step();
        bus.enableMask  = 4'b1101;
        bus.ringRequest = 4'b0010;
        step();
        chk_all("mask_exit", 0, 0, 2'd1, 4'b0000, 4'b0000);
        step();
        chk_all("mask_ignore", 0, 0, 2'd1, 4'b0000, 4'b0000);
        bus.enableMask  = 4'b1111;
        bus.ringRequest = '0;

        // Reset mid-ring.
        bus.ringRequest = 4'b0101;
        step();
        bus.ringRequest = '0;
        step();
        chk_all("rst_grant", 1, 1, 2'd0, 4'b0101, 4'b0000);
        step();
        resetN = 1'b0;
        step();
        chk_all("rst_mid_ring", 0, 0, 2'd0, 4'b0000, 4'b0000);
        resetN = 1'b1;
        step();
        chk_all("rst_stay_idle", 0, 0, 2'd0, 4'b0000, 4'b0000);
        step();
        chk_all("rst_stay_idle2", 0, 0, 2'd0, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
